uart_core: RTL and testbench
============================

# uart_core

Full-duplex 8N1 UART transceiver: one serial receiver and one serial transmitter sharing a clock, with a byte-wide parallel interface and single-cycle status pulses. It is the physical link layer below the UART-to-memory bridge, which uses it to exchange command, address and data bytes with a host. Baud timing comes from a fixed divider that produces a 4x-oversampled bit clock.

## Interface
- CLOCK_DIVIDE, 1302: clk_i cycles per quarter bit, so one bit cell is 4·CLOCK_DIVIDE cycles. Must be ≥ 2.
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- rx_i  in  1  serial input, idle high.
- tx_o  out  1  serial output, idle high.
- transmit_i  in  1  start-transmit request. Sampled each cycle.
- tx_byte_i  in  8  byte to send. Latched on acceptance.
- received_o  out  1  one-cycle pulse when a valid byte is available on rx_byte_o.
- rx_byte_o  out  8  last received byte. Holds until the next reception overwrites it.
- is_receiving_o  out  1  high while the receive FSM is not idle.
- is_transmitting_o  out  1  high while the transmit FSM is not idle.
- recv_error_o  out  1  one-cycle pulse on a false start bit or a framing error.

## Operation
- **Reset values:** tx_o=1, received_o=0, recv_error_o=0, is_receiving_o=0, is_transmitting_o=0, rx_byte_o=0. Both FSMs go to IDLE.
- **Input sync:** rx_i passes through a 2-flop synchronizer, reset to 1. The receive FSM sees only the synchronized rx.
- **Frame format:** 1 start bit (0), 8 data bits LSB first, stop (1). No parity.
- **Dividers:** RX and TX each have an independent divider. It reloads CLOCK_DIVIDE and emits a tick every CLOCK_DIVIDE cycles. Each FSM also keeps a countdown, in ticks, of quarter-bit units.
- **RX FSM** (RX_IDLE, CHECK_START, READ_BITS, CHECK_STOP, ERROR, DELAY_RESTART, RECEIVED):
  - RX_IDLE: on rx=0, restart the divider, set countdown=2 (half bit), go CHECK_START.
  - CHECK_START: when countdown expires, if rx=0, set countdown=4 and bits=8 and go READ_BITS. Otherwise go ERROR.
  - READ_BITS: each time countdown expires, shift in data = {rx, data[7:1]}, reload countdown=4, decrement bits. After the 8th bit, go CHECK_STOP.
  - CHECK_STOP: when countdown expires, rx=1 goes to RECEIVED, rx=0 goes to ERROR.
  - RECEIVED: rx_byte_o is updated, received_o=1 for this one cycle, next state RX_IDLE.
  - ERROR: recv_error_o=1 for this one cycle, set countdown=8, go DELAY_RESTART.
  - DELAY_RESTART: wait 2 bit cells, then RX_IDLE.
- **TX FSM** (TX_IDLE, SENDING, TX_DELAY):
  - TX_IDLE: on transmit_i=1, latch tx_byte_i, drive tx_o=0, set countdown=4, bits=8, go SENDING.
  - SENDING: each time countdown expires, if bits remain, drive tx_o = next LSB, shift, bits-1, countdown=4. Otherwise drive tx_o=1, set countdown=8, go TX_DELAY.
  - TX_DELAY: when countdown expires, go TX_IDLE.
- is_transmitting_o = (TX state ≠ TX_IDLE). is_receiving_o = (RX state ≠ RX_IDLE).
- **Busy requests:** transmit_i while TX is not idle is ignored, not queued.
- **Independence:** RX and TX run concurrently. Simultaneous receive and transmit events do not interact.

## Timing
- **Bit cell:** 4·CLOCK_DIVIDE cycles. RX samples at mid-cell.
- **TX start:** tx_o falls in the first cycle after the cycle in which transmit_i is accepted. is_transmitting_o rises in that same first cycle.
- **TX frame:** start bit plus 8 data bits, then tx_o stays high 2 cells before TX_IDLE. is_transmitting_o stays high for 11 cells, ±1 cycle.
- **RX latency:** received_o pulses about 9.5 cells plus 3 cycles after the falling edge of the start bit on rx_i. The 3 cycles are 2 for the synchronizer and 1 for FSM entry.
- **RX re-arm:** after RECEIVED, a new start bit is accepted on the next cycle. After ERROR, rx is ignored for 2 cells.
- **Reset mid-operation:** asynchronous reset immediately forces all reset values. A partial frame is discarded and no pulse is issued.
- **Exclusivity:** received_o and recv_error_o are never high in the same cycle.

## Structure
- A shared package uart_pkg holds:
  - the RX and TX state enumerations;
  - the default CLOCK_DIVIDE;
  - the constants 2 (half cell), 4 (full cell) and 8 (two cells) quarter-bit counts.
- A single module uart_core contains both FSMs. The only natural sub-module is uart_sync2, the 2-flop rx synchronizer.

## Test plan
All scenarios use CLOCK_DIVIDE=4, so one bit cell is 16 cycles.
- **Reset:** assert rst_i mid-cycle with rx_i=1 → all outputs at reset values immediately, tx_o=1.
- **Transmit:** pulse transmit_i with tx_byte_i=0xA5 → tx_o sampled at cell centres reads 0, 1,0,1,0,0,1,0,1, then 1. is_transmitting_o is high for 176±1 cycles. A second transmit_i mid-frame is ignored.
- **Receive:** drive an 8N1 frame for 0x41 on rx_i → exactly one received_o pulse with rx_byte_o=0x41, recv_error_o stays 0, is_receiving_o falls on the cycle after the pulse.
- **False start:** drive rx_i low for 4 cycles, then high → one recv_error_o pulse, no received_o, is_receiving_o high for about 2 cells after the error.
- **Framing error:** frame 0x20 with the stop bit held at 0 → recv_error_o pulse, no received_o, rx_byte_o keeps its previous value.
- **Full duplex:** transmit 0x42 while receiving 0x60 back-to-back frames → both complete correctly. Assert reset mid-frame → no pulse, clean restart on the next frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART core.
package uart_pkg;

  localparam int unsigned CLOCK_DIVIDE_DEFAULT = 1302;

  // Countdown reload values, in quarter-bit ticks
  localparam int unsigned QTR_HALF = 2;
  localparam int unsigned QTR_FULL = 4;
  localparam int unsigned QTR_TWO  = 8;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BITS_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_CHECK_START,
    RX_READ_BITS,
    RX_CHECK_STOP,
    RX_ERROR,
    RX_DELAY_RESTART,
    RX_RECEIVED
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SENDING,
    TX_DELAY
  } tx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial input; resets to the idle-high level.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  // Capture the asynchronous line through two stages
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b1;
      q_o  <= 1'b1;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent receive and transmit FSMs, 4x oversampled.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDE = CLOCK_DIVIDE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              tx_o,
  input  logic              transmit_i,
  input  logic [DATA_W-1:0] tx_byte_i,
  output logic              received_o,
  output logic [DATA_W-1:0] rx_byte_o,
  output logic              is_receiving_o,
  output logic              is_transmitting_o,
  output logic              recv_error_o
);

  localparam int unsigned      DIV_W    = $clog2(CLOCK_DIVIDE + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLOCK_DIVIDE);

  logic rx_sync;

  rx_state_t rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  rx_div_q, rx_div_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BITS_W-1:0] rx_bits_q, rx_bits_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_tick, rx_expired;

  tx_state_t tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_div_q, tx_div_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BITS_W-1:0] tx_bits_q, tx_bits_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_tick, tx_expired, tx_out_d;

  logic received_d, recv_error_d, is_receiving_d, is_transmitting_d;

  uart_sync2 u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_sync)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q        <= RX_IDLE;
      rx_div_q          <= DIV_LOAD;
      rx_cnt_q          <= '0;
      rx_bits_q         <= '0;
      rx_data_q         <= '0;
      tx_state_q        <= TX_IDLE;
      tx_div_q          <= DIV_LOAD;
      tx_cnt_q          <= '0;
      tx_bits_q         <= '0;
      tx_data_q         <= '0;
      tx_o              <= 1'b1;
      received_o        <= 1'b0;
      recv_error_o      <= 1'b0;
      is_receiving_o    <= 1'b0;
      is_transmitting_o <= 1'b0;
      rx_byte_o         <= '0;
    end else begin
      rx_state_q        <= rx_state_d;
      rx_div_q          <= rx_div_d;
      rx_cnt_q          <= rx_cnt_d;
      rx_bits_q         <= rx_bits_d;
      rx_data_q         <= rx_data_d;
      tx_state_q        <= tx_state_d;
      tx_div_q          <= tx_div_d;
      tx_cnt_q          <= tx_cnt_d;
      tx_bits_q         <= tx_bits_d;
      tx_data_q         <= tx_data_d;
      tx_o              <= tx_out_d;
      received_o        <= received_d;
      recv_error_o      <= recv_error_d;
      is_receiving_o    <= is_receiving_d;
      is_transmitting_o <= is_transmitting_d;
      if (received_d) begin
        rx_byte_o <= rx_data_q;
      end
    end
  end

  // Receive divider, countdown and next-state
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bits_d  = rx_bits_q;
    rx_data_d  = rx_data_q;
    rx_tick    = (rx_div_q == DIV_W'(1));
    rx_div_d   = rx_tick ? DIV_LOAD : rx_div_q - DIV_W'(1);
    rx_cnt_d   = rx_tick ? rx_cnt_q - CNT_W'(1) : rx_cnt_q;
    rx_expired = rx_tick && (rx_cnt_d == '0);
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_div_d   = DIV_LOAD;
          rx_cnt_d   = CNT_W'(QTR_HALF);
          rx_state_d = RX_CHECK_START;
        end
      end
      RX_CHECK_START: begin
        if (rx_expired) begin
          if (!rx_sync) begin
            rx_cnt_d   = CNT_W'(QTR_FULL);
            rx_bits_d  = BITS_W'(DATA_W);
            rx_state_d = RX_READ_BITS;
          end else begin
            rx_state_d = RX_ERROR;
          end
        end
      end
      RX_READ_BITS: begin
        if (rx_expired) begin
          rx_data_d  = {rx_sync, rx_data_q[DATA_W-1:1]};
          rx_cnt_d   = CNT_W'(QTR_FULL);
          rx_bits_d  = rx_bits_q - BITS_W'(1);
          rx_state_d = (rx_bits_q == BITS_W'(1)) ? RX_CHECK_STOP : RX_READ_BITS;
        end
      end
      RX_CHECK_STOP: begin
        if (rx_expired) begin
          rx_state_d = rx_sync ? RX_RECEIVED : RX_ERROR;
        end
      end
      RX_ERROR: begin
        rx_div_d   = DIV_LOAD;
        rx_cnt_d   = CNT_W'(QTR_TWO);
        rx_state_d = RX_DELAY_RESTART;
      end
      RX_DELAY_RESTART: begin
        if (rx_expired) begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_RECEIVED: rx_state_d = RX_IDLE;
      default:     rx_state_d = RX_IDLE;
    endcase
  end

  // Transmit divider, countdown, serializer and next-state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bits_d  = tx_bits_q;
    tx_data_d  = tx_data_q;
    tx_out_d   = tx_o;
    tx_tick    = (tx_div_q == DIV_W'(1));
    tx_div_d   = tx_tick ? DIV_LOAD : tx_div_q - DIV_W'(1);
    tx_cnt_d   = tx_tick ? tx_cnt_q - CNT_W'(1) : tx_cnt_q;
    tx_expired = tx_tick && (tx_cnt_d == '0);
    case (tx_state_q)
      TX_IDLE: begin
        if (transmit_i) begin
          tx_data_d  = tx_byte_i;
          tx_div_d   = DIV_LOAD;
          tx_cnt_d   = CNT_W'(QTR_FULL);
          tx_bits_d  = BITS_W'(DATA_W);
          tx_out_d   = 1'b0;
          tx_state_d = TX_SENDING;
        end
      end
      TX_SENDING: begin
        if (tx_expired) begin
          if (tx_bits_q != '0) begin
            tx_out_d  = tx_data_q[0];
            tx_data_d = {1'b0, tx_data_q[DATA_W-1:1]};
            tx_bits_d = tx_bits_q - BITS_W'(1);
            tx_cnt_d  = CNT_W'(QTR_FULL);
          end else begin
            tx_out_d   = 1'b1;
            tx_cnt_d   = CNT_W'(QTR_TWO);
            tx_state_d = TX_DELAY;
          end
        end
      end
      TX_DELAY: begin
        if (tx_expired) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Status outputs follow the next state so they line up with it once registered
  always_comb begin
    received_d        = (rx_state_d == RX_RECEIVED);
    recv_error_d      = (rx_state_d == RX_ERROR);
    is_receiving_d    = (rx_state_d != RX_IDLE);
    is_transmitting_d = (tx_state_d != TX_IDLE);
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core with a 16-cycle bit cell.
module tb_uart_core;

  localparam int unsigned CD   = 4;
  localparam int          CELL = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       tx_o;
  logic       transmit_i;
  logic [7:0] tx_byte_i;
  logic       received_o;
  logic [7:0] rx_byte_o;
  logic       is_receiving_o;
  logic       is_transmitting_o;
  logic       recv_error_o;

  int checks = 0;
  int errors = 0;

  // Receive monitor results
  int         rx_pulses, err_pulses, pulse_cyc, busy_after_err, both_high;
  logic [7:0] rx_bytes [4];
  logic       busy_at_pulse, busy_after_pulse;

  // Transmit observation results
  logic [9:0] tx_cells;
  int         tx_busy_cycles;
  logic       tx_first_level, tx_first_busy, tx_end_level;

  always #5 clk_i = ~clk_i;

  uart_core #(.CLOCK_DIVIDE(CD)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .rx_i              (rx_i),
    .tx_o              (tx_o),
    .transmit_i        (transmit_i),
    .tx_byte_i         (tx_byte_i),
    .received_o        (received_o),
    .rx_byte_o         (rx_byte_o),
    .is_receiving_o    (is_receiving_o),
    .is_transmitting_o (is_transmitting_o),
    .recv_error_o      (recv_error_o)
  );

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CELL) @(negedge clk_i);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk_i);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic monitor_rx(input int ncyc);
    logic want_next, err_seen;
    rx_pulses = 0; err_pulses = 0; pulse_cyc = 0; busy_after_err = 0;
    busy_at_pulse = 1'b0; busy_after_pulse = 1'b1;
    want_next = 1'b0; err_seen = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_i);
      if (received_o && recv_error_o) both_high++;
      if (want_next) begin
        busy_after_pulse = is_receiving_o;
        want_next = 1'b0;
      end
      if (received_o) begin
        if (rx_pulses < 4) rx_bytes[rx_pulses] = rx_byte_o;
        rx_pulses++;
        pulse_cyc = c;
        busy_at_pulse = is_receiving_o;
        want_next = 1'b1;
      end
      if (recv_error_o) begin
        err_pulses++;
        err_seen = 1'b1;
      end else if (err_seen && is_receiving_o) begin
        busy_after_err++;
      end
    end
  endtask

  task automatic run_tx(input logic [7:0] b, input logic inject);
    @(negedge clk_i);
    transmit_i = 1'b1;
    tx_byte_i  = b;
    tx_busy_cycles = 0;
    tx_cells = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        tx_first_level = tx_o;
        tx_first_busy  = is_transmitting_o;
        transmit_i     = 1'b0;
      end
      if (is_transmitting_o) tx_busy_cycles++;
      if (c >= 9 && ((c - 9) % CELL) == 0 && ((c - 9) / CELL) < 10)
        tx_cells[(c - 9) / CELL] = tx_o;
      if (inject && c == 40) begin
        transmit_i = 1'b1;
        tx_byte_i  = 8'hFF;
      end
      if (inject && c == 41) transmit_i = 1'b0;
    end
    tx_end_level = tx_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; rx_i = 1'b1; transmit_i = 1'b0; tx_byte_i = 8'h00;
    #7 rst_i = 1'b1;
    #1;
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_o); end
    checks++; if (received_o !== 1'b0) begin errors++; $display("FAIL reset_received got %b exp 0", received_o); end
    checks++; if (recv_error_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", recv_error_o); end
    checks++; if (is_receiving_o !== 1'b0) begin errors++; $display("FAIL reset_rxbusy got %b exp 0", is_receiving_o); end
    checks++; if (is_transmitting_o !== 1'b0) begin errors++; $display("FAIL reset_txbusy got %b exp 0", is_transmitting_o); end
    checks++; if (rx_byte_o !== 8'h00) begin errors++; $display("FAIL reset_rxbyte got %h exp 00", rx_byte_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_transmit();
    logic [9:0] exp;
    exp = {1'b1, 8'hA5, 1'b0};
    run_tx(8'hA5, 1'b1);
    checks++; if (tx_first_level !== 1'b0) begin errors++; $display("FAIL tx_start_level got %b exp 0", tx_first_level); end
    checks++; if (tx_first_busy !== 1'b1) begin errors++; $display("FAIL tx_start_busy got %b exp 1", tx_first_busy); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_cells[k] !== exp[k]) begin
        errors++; $display("FAIL tx_cell%0d got %b exp %b", k, tx_cells[k], exp[k]);
      end
    end
    checks++;
    if (tx_busy_cycles < 175 || tx_busy_cycles > 177) begin
      errors++; $display("FAIL tx_busy_len got %0d exp 176+-1", tx_busy_cycles);
    end
    checks++; if (tx_end_level !== 1'b1) begin errors++; $display("FAIL tx_idle_level got %b exp 1", tx_end_level); end
  endtask

  task automatic test_receive();
    fork
      drive_rx_frame(8'h41, 1'b1);
      monitor_rx(220);
    join
    checks++; if (rx_pulses != 1) begin errors++; $display("FAIL rx_pulses got %0d exp 1", rx_pulses); end
    checks++; if (rx_bytes[0] !== 8'h41) begin errors++; $display("FAIL rx_byte got %h exp 41", rx_bytes[0]); end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL rx_err got %0d exp 0", err_pulses); end
    checks++;
    if (pulse_cyc < 154 || pulse_cyc > 158) begin
      errors++; $display("FAIL rx_latency got %0d exp 156+-2", pulse_cyc);
    end
    checks++;
    if (busy_at_pulse !== 1'b1 || busy_after_pulse !== 1'b0) begin
      errors++; $display("FAIL rx_busy_fall got %b%b exp 10", busy_at_pulse, busy_after_pulse);
    end
  endtask

  task automatic test_false_start();
    fork
      begin
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
      end
      monitor_rx(100);
    join
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL fs_err got %0d exp 1", err_pulses); end
    checks++; if (rx_pulses != 0) begin errors++; $display("FAIL fs_received got %0d exp 0", rx_pulses); end
    checks++;
    if (busy_after_err < 30 || busy_after_err > 34) begin
      errors++; $display("FAIL fs_delay got %0d exp 32+-2", busy_after_err);
    end
  endtask

  task automatic test_framing_error();
    fork
      drive_rx_frame(8'h20, 1'b0);
      monitor_rx(230);
    join
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL fe_err got %0d exp 1", err_pulses); end
    checks++; if (rx_pulses != 0) begin errors++; $display("FAIL fe_received got %0d exp 0", rx_pulses); end
    checks++; if (rx_byte_o !== 8'h41) begin errors++; $display("FAIL fe_rxbyte got %h exp 41", rx_byte_o); end
  endtask

  task automatic test_full_duplex();
    logic [9:0] exp;
    exp = {1'b1, 8'h42, 1'b0};
    fork
      run_tx(8'h42, 1'b0);
      begin
        drive_rx_frame(8'h60, 1'b1);
        drive_rx_frame(8'h60, 1'b1);
      end
      monitor_rx(360);
    join
    checks++; if (tx_cells !== exp) begin errors++; $display("FAIL fd_tx_frame got %b exp %b", tx_cells, exp); end
    checks++; if (rx_pulses != 2) begin errors++; $display("FAIL fd_rx_pulses got %0d exp 2", rx_pulses); end
    checks++;
    if (rx_bytes[0] !== 8'h60 || rx_bytes[1] !== 8'h60) begin
      errors++; $display("FAIL fd_rx_bytes got %h %h exp 60 60", rx_bytes[0], rx_bytes[1]);
    end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL fd_err got %0d exp 0", err_pulses); end
  endtask

  task automatic test_reset_mid_frame();
    fork
      begin
        @(negedge clk_i);
        transmit_i = 1'b1; tx_byte_i = 8'h00;
        @(negedge clk_i);
        transmit_i = 1'b0;
        repeat (78) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rm_tx got %b exp 1", tx_o); end
        checks++; if (is_transmitting_o !== 1'b0) begin errors++; $display("FAIL rm_txbusy got %b exp 0", is_transmitting_o); end
        checks++; if (is_receiving_o !== 1'b0) begin errors++; $display("FAIL rm_rxbusy got %b exp 0", is_receiving_o); end
        checks++; if (rx_byte_o !== 8'h00) begin errors++; $display("FAIL rm_rxbyte got %h exp 00", rx_byte_o); end
        repeat (90) @(negedge clk_i);
        rst_i = 1'b0;
      end
      drive_rx_frame(8'h33, 1'b1);
      monitor_rx(200);
    join
    checks++;
    if (rx_pulses != 0 || err_pulses != 0) begin
      errors++; $display("FAIL rm_no_pulse got %0d/%0d exp 0/0", rx_pulses, err_pulses);
    end
    fork
      drive_rx_frame(8'h5A, 1'b1);
      monitor_rx(200);
    join
    checks++;
    if (rx_pulses != 1 || rx_bytes[0] !== 8'h5A) begin
      errors++; $display("FAIL rm_restart got %0d pulses byte %h exp 1 5a", rx_pulses, rx_bytes[0]);
    end
    checks++; if (err_pulses != 0) begin errors++; $display("FAIL rm_restart_err got %0d exp 0", err_pulses); end
    checks++; if (both_high != 0) begin errors++; $display("FAIL exclusive got %0d exp 0", both_high); end
  endtask

  initial begin
    both_high = 0;
    test_reset();
    test_transmit();
    test_receive();
    test_false_start();
    test_framing_error();
    test_full_duplex();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
